// File: rtl/mds_mult_seq.sv
// Sequential Twofish MDS matrix-vector multiplier over GF(2^8).
// Horner evaluation, MSB-first over the constant bits, STEPS constant bits per clock.
module mds_mult_seq #(
  parameter logic [8:0] POLY  = 9'h169,
  parameter int         STEPS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  // Handshake: a word moves on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; y holds while out_valid waits.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] STEP_INC = 3'(STEPS);
  localparam logic [2:0] LAST_CNT = 3'(8 - STEPS);

  generate
    if ((STEPS < 1) || (STEPS > 8) || ((8 % STEPS) != 0)) begin : g_bad_steps
      $error("mds_mult_seq: STEPS must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [7:0]  r_acc [4];

  logic [7:0]  w_acc [4];
  logic [7:0]  w_nxt;
  logic [7:0]  w_c;
  logic [2:0]  w_bit;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY[7:0] : 8'h00);
  endfunction

  function automatic logic [7:0] mds_coef(input logic [1:0] i, input logic [1:0] j);
    logic [7:0] c;
    case ({i, j})
      4'h0, 4'h7, 4'hA, 4'hD: c = 8'h01;
      4'h2, 4'h3, 4'h4, 4'h9, 4'hF: c = 8'h5B;
      default: c = 8'hEF;
    endcase
    return c;
  endfunction

  // STEPS Horner sub-steps chained combinationally; b runs 7 - r_cnt downwards.
  always_comb begin
    w_acc = r_acc;
    w_nxt = '0;
    w_c   = '0;
    w_bit = '0;
    for (int s = 0; s < STEPS; s++) begin
      w_bit = 3'd7 - r_cnt - 3'(s);
      for (int i = 0; i < 4; i++) begin
        w_nxt = xtime(w_acc[i]);
        for (int j = 0; j < 4; j++) begin
          w_c = mds_coef(2'(i), 2'(j));
          if (w_c[w_bit]) w_nxt = w_nxt ^ r_x[8*j +: 8];
        end
        w_acc[i] = w_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      for (int i = 0; i < 4; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= x;
            r_cnt   <= '0;
            r_state <= S_BUSY;
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
          end
        end
        S_BUSY: begin
          for (int i = 0; i < 4; i++) r_acc[i] <= w_acc[i];
          if (r_cnt == LAST_CNT) begin
            r_y     <= {w_acc[3], w_acc[2], w_acc[1], w_acc[0]};
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + STEP_INC;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;

endmodule

// File: doc/mds_mult_seq.md
Name: mds_mult_seq

Overview:
- Sequential Twofish MDS matrix-vector multiplier over GF(2^8). It replaces the per-constant combinational multipliers (x01/x5B/xEF) in the h-function output stage.
- It accepts one 32-bit word, computes y = MDS * x using bit-serial shift-and-add (Horner, MSB-first over the constant bits), and returns the 32-bit result.
- A valid/ready handshake is used on both the input and output sides.
- Throughput and area are traded through STEPS: the number of constant bits processed per clock.

Parameters:
- POLY, 9'h169, GF(2^8) reduction polynomial (x^8+x^6+x^5+x^3+1, the Twofish MDS polynomial).
- STEPS, 1, constant bits processed per cycle. Legal values are 1, 2, 4 and 8. Compute latency is 8/STEPS cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x is valid.
- in_ready  output  1  block can accept x.
- x  input  32  input word. x0 = x[7:0] … x3 = x[31:24].
- out_valid  output  1  y is valid.
- out_ready  input  1  downstream accepts y.
- y  output  32  result word. y0 = y[7:0] … y3 = y[31:24].

Behaviour:
- MDS rows (y_i = XOR over j of M[i][j]·x_j):
  - Row 0: 01 EF 5B 5B
  - Row 1: 5B EF EF 01
  - Row 2: EF 5B 01 EF
  - Row 3: EF 01 EF 5B
- State machine: IDLE, BUSY, DONE.
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, y=0, step counter=0, accumulators=0, x latch=0. Reset asserted mid-operation aborts the computation immediately. No output is produced for the aborted word.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1: latch x, clear the four accumulators acc0..acc3, load counter=0, go to BUSY.
- BUSY:
  - in_ready=0. in_valid is ignored.
  - Each cycle performs STEPS sub-steps, with b running 7 down to 0 across the whole computation.
  - One sub-step: acc_i <= xtime(acc_i) XOR (XOR over j of (M[i][j][b] ? x_j : 0)).
  - xtime(a) = (a<<1) XOR (a[7] ? POLY[7:0] : 0).
  - The sub-steps are combinationally chained within a cycle.
  - The counter advances by STEPS per cycle. After 8/STEPS cycles, register y={acc3,acc2,acc1,acc0} and go to DONE.
- DONE:
  - out_valid=1, y is stable, in_ready=0.
  - On a clock edge with out_ready=1: out_valid drops to 0 and the state returns to IDLE. The next word is accepted no earlier than the following edge.
  - While out_ready=0, y and out_valid hold indefinitely.
- Latency: acceptance edge → out_valid high after 8/STEPS + 1 edges.
  - STEPS=1: 9 cycles.
  - STEPS=8: 2 cycles.
  - Minimum initiation interval is 8/STEPS + 2 cycles.
- y is updated only on the BUSY→DONE transition. It holds its last result through IDLE.
- Arithmetic is carry-free (XOR); there is no overflow. All intermediate values are 8-bit.
- x=0 gives y=0. A constant bit of 0 contributes nothing. Row entry 01 has only b=0 set.
- Illegal STEPS values (anything other than 1, 2, 4, 8) are out of scope. The implementation should stop elaboration with an error if STEPS does not divide 8.

Test Plan:
- Reset/idle: hold rst_n=0, then release → in_ready=1, out_valid=0, y=0x00000000.
- Unit vectors, STEPS=1:
  - x=0x00000001 → y=0xEFEF5B01 after 9 cycles.
  - x=0x00000100 → y=0x015BEFEF.
  - x=0x00000000 → y=0x00000000.
- Reduction path: x=0x00000002 → y=0xB7B7B602. This checks 5B·02=B6 and EF·02=B7 (reduced by 0x169).
- Exhaustive byte sweep: for each of x0 = 0..255 with other bytes 0, apply the word and write y to a file, one %b line per word. Compare y0/y1/y2 against the 01/5B/EF single-constant golden outputs. Repeat with STEPS=1, 2, 4 and 8; results must be identical and latency must be 9, 5, 3 and 2 respectively.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → y and out_valid stable and in_ready=0 throughout. Pulse in_valid with a new x during this window → it is ignored. Raise out_ready → out_valid falls, then the new word is accepted.
- Reset mid-BUSY: assert rst_n=0 at cycle 4 of a STEPS=1 computation → immediate IDLE with y=0. The next word x=0x01000000 yields 0x5BEF015B.
